// File: rtl/updn_counter_sat_wrap.sv
// updn_counter_sat_wrap: bounded up/down counter with saturate/wrap limits and optional sequential BCD converter (UPDN_COUNTER_BCD_EN)
module updn_counter_sat_wrap #(
  parameter int WIDTH      = 8,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 2**WIDTH-1,
  parameter bit WRAP       = 1'b0,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic                    LOAD,
  input  logic [WIDTH-1:0]        LOAD_VAL,
  input  logic                    ENABLE,
  input  logic                    UPDN,
  output logic [WIDTH-1:0]        VALUE,
  output logic                    AT_MAX,
  output logic                    AT_MIN,
  output logic                    WRAP_PULSE,
  output logic                    SAT,
  output logic [4*BCD_DIGITS-1:0] BCD_VALUE,
  output logic                    BCD_VALID
);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MIN_X = {1'b0, MIN_W};
  localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_W};
  logic             lim;
  logic             step;
  logic [WIDTH:0]   lx;
  logic [WIDTH-1:0] clamp;
  assign AT_MAX = VALUE == MAX_W;
  assign AT_MIN = VALUE == MIN_W;
  assign lim    = UPDN ? AT_MAX : AT_MIN;
  assign step   = !CLR && !LOAD && ENABLE;
  // One extra bit keeps the limit compares free of constant-result forms at the extremes
  assign lx     = {1'b0, LOAD_VAL};
  assign clamp  = (lx + (WIDTH+1)'(1)) <= MIN_X ? MIN_W : lx > MAX_X ? MAX_W : LOAD_VAL;
  // Count register with CLR > LOAD > ENABLE priority; limit tested before stepping so no overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VALUE      <= MIN_W;
      WRAP_PULSE <= 1'b0;
      SAT        <= 1'b0;
    end else begin
      WRAP_PULSE <= step && lim && WRAP;
      SAT        <= step && lim && !WRAP;
      VALUE      <= CLR ? MIN_W :
                    LOAD ? clamp :
                    !ENABLE ? VALUE :
                    !lim ? (UPDN ? VALUE + WIDTH'(1) : VALUE - WIDTH'(1)) :
                    !WRAP ? VALUE :
                    UPDN ? MIN_W : MAX_W;
    end
  end
`ifdef UPDN_COUNTER_BCD_EN
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int CW = $clog2(WIDTH+1);
  localparam int BW = 4*BCD_DIGITS;
  state_t           state;
  logic             dirty;
  logic             restart;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  assign restart = dirty || VALUE != snap;
  // Add-3 correction of every digit that would overflow past 9 on the next shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // Double-dabble sequencer: any VALUE change (re)starts from a fresh snapshot, one bit per edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      dirty     <= 1'b1;
      snap      <= '0;
      sh        <= '0;
      acc       <= '0;
      cnt       <= '0;
      BCD_VALUE <= '0;
      BCD_VALID <= 1'b0;
    end else if (restart) begin
      state     <= SHIFT;
      dirty     <= 1'b0;
      snap      <= VALUE;
      sh        <= VALUE;
      acc       <= '0;
      cnt       <= CW'(WIDTH);
      BCD_VALID <= 1'b0;
    end else if (state == SHIFT) begin
      {acc, sh} <= {adj, sh} << 1;
      cnt       <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        BCD_VALUE <= {adj[BW-2:0], sh[WIDTH-1]};
        BCD_VALID <= 1'b1;
        state     <= IDLE;
      end
    end
  end
`else
  assign BCD_VALUE = '0;
  assign BCD_VALID = 1'b0;
`endif
endmodule

// File: tb/tb_updn_counter_sat_wrap.sv
// tb_updn_counter_sat_wrap: randomized and directed checks of a saturating and a wrapping counter instance against a spec-level model
module tb_updn_counter_sat_wrap;
  localparam int W = 8;
  localparam bit BCD_ON =
`ifdef UPDN_COUNTER_BCD_EN
    1'b1;
`else
    1'b0;
`endif
  logic CLK, RST;
  logic clr [2], load [2], en [2], updn [2];
  logic [7:0] lval [2];
  logic [7:0] value [2];
  logic at_max [2], at_min [2], wrapp [2], sat [2], bcdv [2];
  logic [11:0] bcd [2];
  int mn [2] = '{0, 10};
  int mx [2] = '{255, 59};
  bit wr [2] = '{1'b0, 1'b1};
  int mv [2], run [2], prev [2], lbcd [2];
  bit mw [2], ms [2];
  int vecs = 0, errs = 0;

  updn_counter_sat_wrap #(.WIDTH(W)) dut_sat (
    .CLK(CLK), .RST(RST), .CLR(clr[0]), .LOAD(load[0]), .LOAD_VAL(lval[0]), .ENABLE(en[0]), .UPDN(updn[0]),
    .VALUE(value[0]), .AT_MAX(at_max[0]), .AT_MIN(at_min[0]), .WRAP_PULSE(wrapp[0]), .SAT(sat[0]),
    .BCD_VALUE(bcd[0]), .BCD_VALID(bcdv[0]));
  updn_counter_sat_wrap #(.WIDTH(W), .MIN_VAL(10), .MAX_VAL(59), .WRAP(1'b1)) dut_wrap (
    .CLK(CLK), .RST(RST), .CLR(clr[1]), .LOAD(load[1]), .LOAD_VAL(lval[1]), .ENABLE(en[1]), .UPDN(updn[1]),
    .VALUE(value[1]), .AT_MAX(at_max[1]), .AT_MIN(at_min[1]), .WRAP_PULSE(wrapp[1]), .SAT(sat[1]),
    .BCD_VALUE(bcd[1]), .BCD_VALID(bcdv[1]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int to_bcd(int v);
    int r = 0;
    for (int i = 0; i < 3; i++) begin
      r |= (v % 10) << (4*i);
      v /= 10;
    end
    return r;
  endfunction

  function automatic logic ev(int d);
    return BCD_ON && run[d] >= W+1;
  endfunction

  function automatic logic [11:0] eb(int d);
    return BCD_ON ? 12'(lbcd[d]) : 12'h0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = mn[d]; mw[d] = 0; ms[d] = 0; run[d] = 0; prev[d] = -1; lbcd[d] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      clr[d] = 0; load[d] = 0; en[d] = 0; updn[d] = 0; lval[d] = 0;
    end
  endtask

  // Advance model by one edge from current inputs, then let the DUT take the same edge
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int pre = mv[d];
      int lv = int'(lval[d]);
      bit lim = updn[d] ? pre == mx[d] : pre == mn[d];
      run[d] = (pre != prev[d]) ? 1 : run[d] + 1;
      prev[d] = pre;
      if (run[d] == W+1) lbcd[d] = to_bcd(pre);
      mw[d] = 0; ms[d] = 0;
      if (clr[d]) mv[d] = mn[d];
      else if (load[d]) mv[d] = lv < mn[d] ? mn[d] : lv > mx[d] ? mx[d] : lv;
      else if (en[d]) begin
        if (!lim) mv[d] = updn[d] ? pre + 1 : pre - 1;
        else if (wr[d]) begin mv[d] = updn[d] ? mn[d] : mx[d]; mw[d] = 1; end
        else ms[d] = 1;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (value[d] !== 8'(mn[d]) || at_min[d] !== 1'b1 || at_max[d] !== 1'b0 || wrapp[d] !== 1'b0 ||
          sat[d] !== 1'b0 || bcdv[d] !== 1'b0 || bcd[d] !== 12'h0) begin
        errs++;
        $display("FAIL reset dut%0d: value=%0d at_min=%b at_max=%b wrap=%b sat=%b bcd=%h bcdv=%b, expected value=%0d 1 0 0 0 000 0",
                 d, value[d], at_min[d], at_max[d], wrapp[d], sat[d], bcd[d], bcdv[d], mn[d]);
      end
    end
    RST = 0;
    model_reset();
  endtask

  task automatic test_sat_count();
    for (int d = 0; d < 2; d++) begin en[d] = 1; updn[d] = 1; end
    for (int i = 0; i < 300; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (value[d] !== 8'(mv[d]) || sat[d] !== ms[d] || wrapp[d] !== mw[d] || at_max[d] !== (mv[d] == mx[d])) begin
          errs++;
          $display("FAIL sat_count dut%0d edge%0d: value=%0d sat=%b wrap=%b at_max=%b, expected %0d %b %b %b",
                   d, i+1, value[d], sat[d], wrapp[d], at_max[d], mv[d], ms[d], mw[d], mv[d] == mx[d]);
        end
      end
      if (i == 254 || i == 299) begin
        vecs++;
        if (value[0] !== 8'd255 || at_max[0] !== 1'b1 || wrapp[0] !== 1'b0 || sat[0] !== (i == 299)) begin
          errs++;
          $display("FAIL sat_reach edge%0d: value=%0d at_max=%b wrap=%b sat=%b, expected 255 1 0 %b",
                   i+1, value[0], at_max[0], wrapp[0], sat[0], i == 299);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [7:0] want_v [4] = '{8'd59, 8'd10, 8'd10, 8'd59};
    logic want_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    idle_inputs();
    for (int s = 0; s < 4; s++) begin
      load[1] = s == 0; lval[1] = 8'd59;
      en[1] = s == 1 || s == 3; updn[1] = s == 1;
      tick();
      vecs++;
      if (value[1] !== want_v[s] || wrapp[1] !== want_w[s] || sat[1] !== 1'b0 ||
          value[1] !== 8'(mv[1]) || wrapp[1] !== mw[1]) begin
        errs++;
        $display("FAIL wrap step%0d: value=%0d wrap=%b sat=%b, expected %0d %b 0", s, value[1], wrapp[1], sat[1], want_v[s], want_w[s]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clr_load();
    logic [7:0] vals [3] = '{8'd40, 8'd5, 8'd200};
    for (int s = 0; s < 3; s++) begin
      for (int d = 0; d < 2; d++) begin
        clr[d] = s == 0; load[d] = 1; lval[d] = vals[s]; en[d] = 1; updn[d] = 1;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (value[d] !== 8'(mv[d]) || wrapp[d] !== 1'b0 || sat[d] !== 1'b0) begin
          errs++;
          $display("FAIL clr_load dut%0d step%0d: value=%0d wrap=%b sat=%b, expected %0d 0 0", d, s, value[d], wrapp[d], sat[d], mv[d]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_bcd_latency();
    int rise = -1;
    idle_inputs();
    load[0] = 1; lval[0] = 8'd237;
    tick();
    load[0] = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vecs++;
      if (bcdv[0] !== ev(0) || bcd[0] !== eb(0)) begin
        errs++;
        $display("FAIL bcd_latency k%0d: bcdv=%b bcd=%h, expected %b %h", k, bcdv[0], bcd[0], ev(0), eb(0));
      end
      if (rise < 0 && bcdv[0] === 1'b1) rise = k;
    end
    vecs++;
    if (rise !== (BCD_ON ? W+1 : -1) || bcd[0] !== (BCD_ON ? 12'h237 : 12'h0)) begin
      errs++;
      $display("FAIL bcd_237: rise_edge=%0d bcd=%h, expected %0d %h", rise, bcd[0], BCD_ON ? W+1 : -1, BCD_ON ? 12'h237 : 12'h0);
    end
  endtask

  task automatic test_bcd_restart();
    idle_inputs();
    for (int k = 0; k < 18; k++) begin
      load[0] = k == 0 || k == 3;
      lval[0] = k == 0 ? 8'd100 : 8'd45;
      tick();
      vecs++;
      if (bcdv[0] !== ev(0) || bcd[0] !== eb(0) || (bcdv[0] === 1'b1 && bcd[0] === 12'h100)) begin
        errs++;
        $display("FAIL bcd_restart k%0d: bcdv=%b bcd=%h, expected %b %h and never 100 valid", k, bcdv[0], bcd[0], ev(0), eb(0));
      end
    end
    vecs++;
    if (bcd[0] !== (BCD_ON ? 12'h045 : 12'h0) || bcdv[0] !== BCD_ON) begin
      errs++;
      $display("FAIL bcd_045: bcd=%h bcdv=%b, expected %h %b", bcd[0], bcdv[0], BCD_ON ? 12'h045 : 12'h0, BCD_ON);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    int rise [2] = '{-1, -1};
    for (int d = 0; d < 2; d++) begin en[d] = 1; updn[d] = 1; end
    repeat (5) tick();
    #2 RST = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (value[d] !== 8'(mn[d]) || bcdv[d] !== 1'b0 || wrapp[d] !== 1'b0 || sat[d] !== 1'b0) begin
        errs++;
        $display("FAIL async_reset dut%0d: value=%0d bcdv=%b wrap=%b sat=%b, expected %0d 0 0 0", d, value[d], bcdv[d], wrapp[d], sat[d], mn[d]);
      end
    end
    model_reset();
    idle_inputs();
    @(posedge CLK);
    #3 RST = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (bcdv[d] !== ev(d) || bcd[d] !== eb(d) || value[d] !== 8'(mn[d])) begin
          errs++;
          $display("FAIL post_reset dut%0d k%0d: bcdv=%b bcd=%h value=%0d, expected %b %h %0d", d, k, bcdv[d], bcd[d], value[d], ev(d), eb(d), mn[d]);
        end
        if (rise[d] < 0 && bcdv[d] === 1'b1) rise[d] = k;
      end
    end
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (rise[d] !== (BCD_ON ? W+1 : -1) || bcd[d] !== (BCD_ON ? 12'(to_bcd(mn[d])) : 12'h0)) begin
        errs++;
        $display("FAIL reset_bcd dut%0d: rise_edge=%0d bcd=%h, expected %0d %h", d, rise[d], bcd[d], BCD_ON ? W+1 : -1, BCD_ON ? 12'(to_bcd(mn[d])) : 12'h0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit quiet = ((i / 25) % 2) == 1;
      for (int d = 0; d < 2; d++) begin
        clr[d]  = !quiet && $urandom_range(0, 19) == 0;
        load[d] = !quiet && $urandom_range(0, 7) == 0;
        lval[d] = 8'($urandom_range(0, 255));
        en[d]   = !quiet && $urandom_range(0, 3) != 0;
        updn[d] = 1'($urandom_range(0, 1));
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (value[d] !== 8'(mv[d]) || wrapp[d] !== mw[d] || sat[d] !== ms[d] || at_max[d] !== (mv[d] == mx[d]) ||
            at_min[d] !== (mv[d] == mn[d]) || bcdv[d] !== ev(d) || bcd[d] !== eb(d)) begin
          errs++;
          $display("FAIL random dut%0d i%0d: value=%0d wrap=%b sat=%b max=%b min=%b bcdv=%b bcd=%h, expected %0d %b %b %b %b %b %h",
                   d, i, value[d], wrapp[d], sat[d], at_max[d], at_min[d], bcdv[d], bcd[d],
                   mv[d], mw[d], ms[d], mv[d] == mx[d], mv[d] == mn[d], ev(d), eb(d));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sat_count();
    test_wrap();
    test_clr_load();
    test_bcd_latency();
    test_bcd_restart();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
